// File: rtl/v8_param.sv
// v8_param: shared ADC width, pulse generator defaults and FSM state type.
// Imported by v8_pulse_gen.
package v8_param;

  localparam int SIZE_ADC_DATA   = 14;

  localparam int PGEN_RISE_SHIFT = 2;
  localparam int PGEN_TAU_SHIFT  = 4;
  localparam int PGEN_DEAD_TIME  = 8;

  typedef enum logic [1:0] {
    IDLE,
    RISE,
    DECAY
  } pgen_state_t;

endpackage

// File: rtl/v8_pulse_gen.sv
// v8_pulse_gen: linear-rise / exponential-decay pulse source in ADC format.
// Optional V8_PULSE_GEN_BASELINE_EN adds a baseline input the output rests on.
module v8_pulse_gen
  import v8_param::*;
#(
  parameter int RISE_SHIFT = PGEN_RISE_SHIFT,
  parameter int TAU_SHIFT  = PGEN_TAU_SHIFT,
  parameter int DEAD_TIME  = PGEN_DEAD_TIME
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            amp_valid,
  input  logic        [SIZE_ADC_DATA-2:0] amp,
  output logic                            amp_ready,
  output logic signed [SIZE_ADC_DATA-1:0] sample_out,
  output logic                            busy
`ifdef V8_PULSE_GEN_BASELINE_EN
  ,
  input  logic signed [SIZE_ADC_DATA-1:0] baseline
`endif
);

  localparam int W        = SIZE_ADC_DATA;
  localparam int RISE_LEN = 1 << RISE_SHIFT;
  localparam int CW       = RISE_SHIFT + 1;
  localparam int DW       = $clog2(DEAD_TIME + 2);

  localparam logic signed [W:0] SAT_MAX =
    {2'b00, {(W-1){1'b1}}};

  pgen_state_t r_state;
  pgen_state_t w_next;

  logic signed [W-1:0] r_sample;
  logic signed [W-1:0] r_target;
  logic        [W-1:0] r_step;
  logic       [CW-1:0] r_cnt;
  logic       [DW-1:0] r_dead;
  logic                r_rdy_en;

  logic signed [W-1:0] w_bl;
  logic                w_accept;
  logic                w_rise_done;
  logic signed [W-1:0] w_target;
  logic signed   [W:0] w_diff;
  logic        [W-1:0] w_step;
  logic signed [W-1:0] w_first;
  logic signed   [W:0] w_delta;
  logic signed   [W:0] w_shr;
  logic signed   [W:0] w_delta_nx;
  logic signed   [W:0] w_decay_wide;
  logic signed [W-1:0] w_decay;

  // Add an unsigned amplitude with headroom, clamp to the positive ADC max
  function automatic logic signed [W-1:0] sat_add(
    input logic signed [W-1:0] a,
    input logic        [W-2:0] b
  );
    logic signed [W:0] s;
    s = {a[W-1], a} + $signed({2'b00, b});
    if (s > SAT_MAX) begin
      return SAT_MAX[W-1:0];
    end
    return s[W-1:0];
  endfunction

`ifdef V8_PULSE_GEN_BASELINE_EN
  assign w_bl = baseline;
`else
  assign w_bl = '0;
`endif

  assign w_target    = sat_add(r_sample, amp);
  assign w_diff      = {w_target[W-1], w_target} - {r_sample[W-1], r_sample};
  assign w_step      = w_diff[W-1:0] >> RISE_SHIFT;
  assign w_first     = (RISE_LEN == 1) ? w_target : r_sample + w_step;
  assign w_rise_done = (r_cnt == CW'(RISE_LEN - 1));

  // Decay acts on the distance to baseline; a zero shift falls back to -1
  assign w_delta      = {r_sample[W-1], r_sample} - {w_bl[W-1], w_bl};
  assign w_shr        = w_delta >>> TAU_SHIFT;
  assign w_delta_nx   = (w_shr == 0 && w_delta != 0) ? w_delta - 1
                                                     : w_delta - w_shr;
  assign w_decay_wide = w_delta_nx + {w_bl[W-1], w_bl};
  assign w_decay      = w_decay_wide[W-1:0];

  assign sample_out = r_sample;

  // Next state, handshake and busy decode
  always_comb begin
    w_next    = r_state;
    amp_ready = 1'b0;
    busy      = (r_state != IDLE);
    w_accept  = 1'b0;
    unique case (r_state)
      IDLE: begin
        amp_ready = r_rdy_en;
        w_accept  = amp_valid & amp_ready;
        if (w_accept) begin
          w_next = (RISE_LEN == 1) ? DECAY : RISE;
        end
      end
      RISE: begin
        if (w_rise_done) begin
          w_next = DECAY;
        end
      end
      DECAY: begin
        amp_ready = r_rdy_en && (r_dead >= DW'(DEAD_TIME));
        w_accept  = amp_valid & amp_ready;
        if (w_accept) begin
          w_next = (RISE_LEN == 1) ? DECAY : RISE;
        end else if (r_sample == w_bl) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State, sample datapath, rise counter and dead-time counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sample <= w_bl;
      r_target <= '0;
      r_step   <= '0;
      r_cnt    <= '0;
      r_dead   <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        r_target <= w_target;
        r_step   <= w_step;
        r_cnt    <= CW'(1);
        r_sample <= w_first;
        r_dead   <= '0;
      end else begin
        unique case (r_state)
          IDLE: r_sample <= w_bl;
          RISE: begin
            if (w_rise_done) begin
              r_sample <= r_target;
              r_dead   <= '0;
            end else begin
              r_sample <= r_sample + r_step;
              r_cnt    <= r_cnt + CW'(1);
            end
          end
          DECAY: begin
            r_sample <= w_decay;
            if (r_dead < DW'(DEAD_TIME)) begin
              r_dead <= r_dead + DW'(1);
            end
          end
          default: r_sample <= w_bl;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_v8_pulse_gen.sv
// tb_v8_pulse_gen: scoreboard bench for v8_pulse_gen, default build.
// Expected outputs are queued at drive time and popped after each edge.
module tb_v8_pulse_gen;
  import v8_param::*;

  logic                            clk = 1'b0;
  logic                            reset;
  logic                            amp_valid;
  logic        [SIZE_ADC_DATA-2:0] amp;
  logic                            amp_ready;
  logic signed [SIZE_ADC_DATA-1:0] sample_out;
  logic                            busy;

  always #5 clk = ~clk;

  v8_pulse_gen dut (
    .clk        (clk),
    .reset      (reset),
    .amp_valid  (amp_valid),
    .amp        (amp),
    .amp_ready  (amp_ready),
    .sample_out (sample_out),
    .busy       (busy)
`ifdef V8_PULSE_GEN_BASELINE_EN
    ,
    .baseline   ('0)
`endif
  );

  typedef struct {
    int s;
    int b;
    int r;
  } exp_t;

  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int ms = 0;
  int mst = 0;
  int mi = 0;
  int mbase = 0;
  int mtgt = 0;
  int mstep = 0;
  int mdead = 0;
  int mrdy = 0;

  int obs_s;
  int obs_b;
  int obs_r;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_ready();
    return (mrdy != 0 && (mst == 0 || (mst == 2 && mdead >= 8))) ? 1 : 0;
  endfunction

  task automatic model_edge(input int v, input int a, input int r);
    int acc;
    int d;
    if (r != 0) begin
      mst = 0; ms = 0; mdead = 0; mrdy = 0;
    end else begin
      acc = (v != 0 && m_ready() != 0) ? 1 : 0;
      mrdy = 1;
      if (acc != 0) begin
        mbase = ms;
        mtgt  = ms + a;
        if (mtgt > 8191) mtgt = 8191;
        mstep = (mtgt - mbase) / 4;
        mi    = 1;
        ms    = mbase + mstep;
        mst   = 1;
        mdead = 0;
      end else if (mst == 0) begin
        ms = 0;
      end else if (mst == 1) begin
        mi++;
        if (mi == 4) begin
          ms = mtgt; mst = 2; mdead = 0;
        end else begin
          ms = mbase + mi * mstep;
        end
      end else begin
        if (ms == 0) begin
          mst = 0;
        end else begin
          d  = ms / 16;
          ms = (d == 0) ? ms - 1 : ms - d;
          if (mdead < 8) mdead++;
        end
      end
    end
  endtask

  task automatic step(input int v, input int a, input int r);
    exp_t e;
    amp_valid = v[0];
    amp       = a[SIZE_ADC_DATA-2:0];
    reset     = r[0];
    model_edge(v, a, r);
    e.s = ms;
    e.b = (mst != 0) ? 1 : 0;
    e.r = m_ready();
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    obs_s = int'(sample_out);
    obs_b = int'(busy);
    obs_r = int'(amp_ready);
    check("sample", obs_s, e.s);
    check("busy", obs_b, e.b);
    check("ready", obs_r, e.r);
  endtask

  task automatic run_to_idle(input string tag);
    int n;
    n = 0;
    while (obs_b != 0 && n < 2000) begin
      step(0, 0, 0);
      n++;
    end
    check({tag, "_idle"}, obs_b, 0);
    check({tag, "_rdy"}, obs_r, 1);
    check({tag, "_zero"}, obs_s, 0);
  endtask

  int exp028[6] = '{250, 500, 750, 1000, 938, 880};
  int cnt;
  int pre;
  int tgt;

  initial begin
    reset     = 1'b1;
    amp_valid = 1'b0;
    amp       = '0;
    @(negedge clk);

    step(0, 0, 1);
    step(0, 0, 1);
    check("rst_rdy", obs_r, 0);
    step(0, 0, 0);
    check("post_rst_rdy", obs_r, 1);
    step(0, 0, 0);

    step(1, 1000, 0);
    check("r028_0", obs_s, exp028[0]);
    for (int k = 1; k < 6; k++) begin
      step(0, 0, 0);
      check($sformatf("r028_%0d", k), obs_s, exp028[k]);
    end
    run_to_idle("p1");

    step(1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check("flat", obs_s, 0);
      step(0, 0, 0);
    end
    run_to_idle("p0");

    step(1, 1000, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0);
    check("pk_top", obs_s, 1000);
    cnt = 0;
    while (obs_r == 0 && cnt < 50) begin
      step(1, 500, 0);
      cnt++;
    end
    check("dead_wait", cnt, 8);
    pre = obs_s;
    check("pre_pile", pre, 600);
    step(1, 500, 0);
    check("pile_first", obs_s, 725);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("pile_top", obs_s, 1100);
    run_to_idle("pu");

    step(1, 8191, 0);
    check("sat_first", obs_s, 2047);
    for (int k = 0; k < 3; k++) step(0, 0, 0);
    check("sat_top", obs_s, 8191);
    cnt = 0;
    while (obs_r == 0 && cnt < 50) begin
      step(1, 8191, 0);
      cnt++;
    end
    step(1, 8191, 0);
    for (int k = 0; k < 3; k++) begin
      check("sat_pos", (obs_s >= 0) ? 1 : 0, 1);
      step(0, 0, 0);
    end
    check("sat_clamp", obs_s, 8191);
    run_to_idle("sat");

    step(1, 1000, 0);
    step(0, 0, 0);
    check("mid_s2", obs_s, 500);
    step(0, 0, 1);
    check("abort_s", obs_s, 0);
    check("abort_b", obs_b, 0);
    step(0, 0, 0);
    check("abort_r", obs_r, 1);
    check("abort_res", obs_s, 0);

    for (int k = 0; k < 600; k++) begin
      tgt = ($urandom_range(0, 199) == 0) ? 1 : 0;
      step(($urandom_range(0, 5) == 0) ? 1 : 0,
           int'($urandom_range(0, 8191)), tgt);
    end
    run_to_idle("rnd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/v8_pulse_gen.md
V8_PULSE_GEN -- requirements
Module: v8_pulse_gen

Interface
REQ-001 The block SHALL have parameter RISE_SHIFT, default 2, meaning the rise lasts 2^RISE_SHIFT samples.
REQ-002 The block SHALL have parameter TAU_SHIFT, default 4, meaning the decay coefficient is 2^-TAU_SHIFT per sample.
REQ-003 The block SHALL have parameter DEAD_TIME, default 8, meaning the minimum DECAY cycles before a pile-up pulse is accepted.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port amp_valid, input, 1 bit: pulse request.
REQ-007 The block SHALL have port amp, input, SIZE_ADC_DATA-1 bits, unsigned: pulse amplitude.
REQ-008 The block SHALL have port amp_ready, output, 1 bit: a request is accepted on a cycle where amp_valid and amp_ready are both high.
REQ-009 The block SHALL have port sample_out, output, signed SIZE_ADC_DATA bits: ADC-format sample, one per clk, in the format v8_filter consumes.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, RISE and DECAY.
REQ-012 amp_ready SHALL be high in IDLE, and in DECAY once dead_cnt >= DEAD_TIME; it SHALL be low otherwise.
REQ-013 Transitions:
- IDLE: on accept, go to RISE; base = sample_out and target = sat(sample_out + amp).
- RISE: go to DECAY after 2^RISE_SHIFT samples.
- DECAY: on accept, go to RISE; pile-up starts from the current sample_out.
- DECAY: if sample_out == 0 and no accept, go to IDLE.
REQ-014 Rise: step = (target - base) >> RISE_SHIFT; sample i (1..2^RISE_SHIFT-1) = base + i*step; the last rise sample SHALL equal target exactly.
REQ-015 Decay: sample_out <= sample_out - (sample_out >>> TAU_SHIFT); when that shift is 0 and sample_out != 0, sample_out SHALL decrement by 1.
REQ-016 Latency: the first rise sample SHALL appear on the cycle after accept.
REQ-017 sat() SHALL clamp to 2^(SIZE_ADC_DATA-1)-1; sums SHALL be computed at SIZE_ADC_DATA+1 bits before clamping.
REQ-018 dead_cnt SHALL clear on DECAY entry, increment in DECAY, and saturate at DEAD_TIME.
REQ-019 amp = 0 SHALL be accepted and SHALL produce a flat rise (target = base).
REQ-020 In IDLE without the baseline option, sample_out SHALL hold 0.

Reset
REQ-021 While reset is high at a clk edge: state=IDLE, sample_out=0 (or baseline), busy=0, amp_ready=0, dead_cnt=0.
REQ-022 Reset mid-pulse SHALL abort the pulse with no residual.
REQ-023 amp_ready SHALL go high on the first cycle after reset deasserts.

Configuration
REQ-024 With V8_PULSE_GEN_BASELINE_EN defined:
- add input baseline, signed SIZE_ADC_DATA bits, sampled every cycle.
- IDLE output = baseline.
- Decay target is baseline: decay applies to (sample_out - baseline), and DECAY→IDLE occurs when sample_out == baseline.
REQ-025 Without V8_PULSE_GEN_BASELINE_EN: no baseline port, and baseline is constant 0.

Structure
REQ-026 Package v8_param SHALL hold:
- SIZE_ADC_DATA (existing).
- PGEN_RISE_SHIFT, PGEN_TAU_SHIFT and PGEN_DEAD_TIME, used as parameter defaults.
- typedef enum pgen_state_t {IDLE, RISE, DECAY}.
REQ-027 The block SHALL be a single module with no sub-module; the saturating add SHALL be a local function.

Verification
REQ-028 Defaults, amp=1000 accepted at cycle N:
- cycles N+1..N+4 output 250, 500, 750, 1000.
- N+5 outputs 938.
- N+6 outputs 880.
REQ-029 Run a pulse to completion: output reaches 0 via the −1 tail, busy falls the same cycle IDLE is entered, amp_ready rises.
REQ-030 Pile-up timing:
- amp_valid held from DECAY entry: accept occurs exactly when dead_cnt = 8.
- The new rise starts from the then-current sample_out.
REQ-031 Saturation: amp = max, then pile-up amp = max; target clamps to 2^(SIZE_ADC_DATA-1)-1, with no wrap to negative.
REQ-032 Reset asserted during RISE (sample 2 of 4): the next cycle gives sample_out=0, busy=0; the cycle after gives amp_ready=1.
REQ-033 Closed loop: feed sample_out into v8_filter (matched M) with amp=1000; the filter output SHALL settle to a flat top and SHALL return to 0.
